// File: rtl/brick_color_table.sv
// Brick color table: captures a color sequence from the upstream generator into a
// 256-entry table and serves registered reads to the brick drawing logic.
module brick_color_table #(
   parameter logic [7:0]  DEFAULT_COLOR = 8'hFF,
   parameter logic [15:0] STALL_LIMIT   = 16'd1000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       newSeq,
   input  logic [7:0] colorIn,
   input  logic [7:0] colorCount,
   input  logic       rdReq,
   input  logic [7:0] brickIndex,
   output logic [7:0] brickColor,
   output logic       rdValid,
   output logic       tableReady,
   output logic [7:0] fillCount,
   output logic       stallErr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  mem_r [0:255];
   logic [7:0]  prev_count_r, prev_count_s;
   logic [15:0] stall_cnt_r, stall_cnt_s;
   logic [7:0]  fill_count_r, fill_count_s;
   logic        table_ready_r, table_ready_s;
   logic        stall_err_r, stall_err_s;
   logic        wr_en_s;
   logic [7:0]  wr_addr_s;
   logic        advance_s;
   logic [7:0]  brick_color_r;
   logic        rd_valid_r;

   assign advance_s = (colorCount != prev_count_r);

   // Next-state and fill bookkeeping; newSeq overrides any advance in the same cycle
   always_comb begin
      state_s       = state_r;
      prev_count_s  = prev_count_r;
      stall_cnt_s   = stall_cnt_r;
      fill_count_s  = fill_count_r;
      table_ready_s = table_ready_r;
      stall_err_s   = stall_err_r;
      wr_en_s       = 1'b0;
      wr_addr_s     = colorCount - 8'd1;
      if (newSeq) begin
         state_s       = FILL;
         prev_count_s  = colorCount;
         stall_cnt_s   = 16'd0;
         fill_count_s  = 8'd0;
         table_ready_s = 1'b0;
         stall_err_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            FILL: begin
               if (advance_s) begin
                  wr_en_s      = 1'b1;
                  prev_count_s = colorCount;
                  stall_cnt_s  = 16'd0;
                  if (fill_count_r == 8'd255) begin
                     fill_count_s = fill_count_r;
                  end else begin
                     fill_count_s = fill_count_r + 8'd1;
                  end
                  if (colorCount == 8'd255) begin
                     state_s       = READY;
                     table_ready_s = 1'b1;
                  end else begin
                     state_s = FILL;
                  end
               end else begin
                  stall_cnt_s = stall_cnt_r + 16'd1;
                  if (stall_cnt_s >= STALL_LIMIT) begin
                     state_s       = READY;
                     table_ready_s = 1'b1;
                     stall_err_s   = 1'b1;
                  end else begin
                     state_s = FILL;
                  end
               end
            end
            READY: begin
               state_s = READY;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // State and control registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_r       <= IDLE;
         prev_count_r  <= 8'd0;
         stall_cnt_r   <= 16'd0;
         fill_count_r  <= 8'd0;
         table_ready_r <= 1'b0;
         stall_err_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         prev_count_r  <= prev_count_s;
         stall_cnt_r   <= stall_cnt_s;
         fill_count_r  <= fill_count_s;
         table_ready_r <= table_ready_s;
         stall_err_r   <= stall_err_s;
      end
   end

   // Table storage, cleared to the no-color value on reset
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < 256; i++) begin
            mem_r[i] <= DEFAULT_COLOR;
         end
      end else if (wr_en_s) begin
         mem_r[wr_addr_s] <= colorIn;
      end
   end

   // Registered read port; sees pre-write contents and masks a table that is not ready
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         brick_color_r <= DEFAULT_COLOR;
         rd_valid_r    <= 1'b0;
      end else begin
         rd_valid_r <= rdReq;
         if (rdReq) begin
            brick_color_r <= table_ready_r ? mem_r[brickIndex] : DEFAULT_COLOR;
         end
      end
   end

   assign brickColor = brick_color_r;
   assign rdValid    = rd_valid_r;
   assign tableReady = table_ready_r;
   assign fillCount  = fill_count_r;
   assign stallErr   = stall_err_r;

endmodule

// File: tb/tb_brick_color_table.sv
// Self-checking bench for brick_color_table: fixed vectors, directed corner
// sequences and randomized traffic against a behavioural table model.
module tb_brick_color_table;

   localparam logic [7:0] DEF   = 8'hFF;
   localparam int         LIMIT = 1000;

   logic       clk = 1'b0;
   logic       resetN;
   logic       newSeq;
   logic [7:0] colorIn;
   logic [7:0] colorCount;
   logic       rdReq;
   logic [7:0] brickIndex;
   logic [7:0] brickColor;
   logic       rdValid;
   logic       tableReady;
   logic [7:0] fillCount;
   logic       stallErr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   brick_color_table #(
      .DEFAULT_COLOR(8'hFF),
      .STALL_LIMIT  (16'd1000)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .newSeq    (newSeq),
      .colorIn   (colorIn),
      .colorCount(colorCount),
      .rdReq     (rdReq),
      .brickIndex(brickIndex),
      .brickColor(brickColor),
      .rdValid   (rdValid),
      .tableReady(tableReady),
      .fillCount (fillCount),
      .stallErr  (stallErr)
   );

   // Behavioural model: a plain array plus "filling / ready / error" flags
   logic [7:0] m_mem [256];
   bit         m_filling, m_ready, m_err, m_valid;
   logic [7:0] m_prev, m_color;
   int         m_stall, m_fill;

   typedef struct {
      logic       ns;
      logic [7:0] cc;
      logic [7:0] ci;
      logic       rd;
      logic [7:0] idx;
      logic [7:0] e_color;
      logic       e_valid;
      logic       e_ready;
      logic [7:0] e_fill;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_mem[i] = DEF;
      m_filling = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_valid = 1'b0;
      m_prev = 8'd0; m_color = DEF; m_stall = 0; m_fill = 0;
   endtask

   task automatic model_edge();
      logic [7:0] addr;
      if (rdReq) begin
         m_valid = 1'b1;
         m_color = m_ready ? m_mem[brickIndex] : DEF;
      end else begin
         m_valid = 1'b0;
      end
      if (newSeq) begin
         m_filling = 1'b1; m_ready = 1'b0; m_err = 1'b0;
         m_fill = 0; m_prev = colorCount; m_stall = 0;
      end else if (m_filling) begin
         if (colorCount != m_prev) begin
            addr = colorCount - 8'd1;
            m_mem[addr] = colorIn;
            if (m_fill < 255) m_fill++;
            m_prev = colorCount;
            m_stall = 0;
            if (colorCount == 8'd255) begin
               m_filling = 1'b0; m_ready = 1'b1;
            end
         end else begin
            m_stall++;
            if (m_stall >= LIMIT) begin
               m_filling = 1'b0; m_ready = 1'b1; m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic check_model();
      chk("model_color", 32'(brickColor), 32'(m_color));
      chk("model_valid", 32'(rdValid),    32'(m_valid));
      chk("model_ready", 32'(tableReady), 32'(m_ready));
      chk("model_fill",  32'(fillCount),  32'(m_fill));
      chk("model_err",   32'(stallErr),   32'(m_err));
   endtask

   task automatic step(input bit use_model);
      @(posedge clk);
      model_edge();
      #1;
      if (use_model) check_model();
   endtask

   task automatic apply_reset(input bit check);
      resetN = 1'b0;
      model_reset();
      #2;
      if (check) begin
         chk("rst_color", 32'(brickColor), 32'(DEF));
         chk("rst_valid", 32'(rdValid),    32'd0);
         chk("rst_ready", 32'(tableReady), 32'd0);
         chk("rst_fill",  32'(fillCount),  32'd0);
         chk("rst_err",   32'(stallErr),   32'd0);
      end
      @(negedge clk);
      resetN = 1'b1;
   endtask

   task automatic do_read(input logic [7:0] idx, input logic [7:0] exp, input string name);
      rdReq = 1'b1;
      brickIndex = idx;
      step(1'b1);
      rdReq = 1'b0;
      chk(name, 32'(brickColor), 32'(exp));
      chk({name, "_valid"}, 32'(rdValid), 32'd1);
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!tableReady && n < 2000) begin
         step(1'b1);
         n++;
      end
      chk(name, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{1'b0, 8'd5, 8'hAA, 1'b1, 8'd0, 8'hFF, 1'b1, 1'b0, 8'd0};
      vecs[1] = '{1'b1, 8'd5, 8'h00, 1'b0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd0};
      vecs[2] = '{1'b0, 8'd6, 8'h11, 1'b1, 8'd5, 8'hFF, 1'b1, 1'b0, 8'd1};
      vecs[3] = '{1'b0, 8'd6, 8'h99, 1'b0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd1};
      vecs[4] = '{1'b0, 8'd7, 8'h22, 1'b0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd2};
      vecs[5] = '{1'b1, 8'd8, 8'h33, 1'b0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd0};
      vecs[6] = '{1'b0, 8'd8, 8'h44, 1'b0, 8'd0, 8'hFF, 1'b0, 1'b0, 8'd0};
      vecs[7] = '{1'b0, 8'd9, 8'h55, 1'b1, 8'd7, 8'hFF, 1'b1, 1'b0, 8'd1};

      newSeq = 1'b0; colorIn = 8'd0; colorCount = 8'd0; rdReq = 1'b0; brickIndex = 8'd0;
      resetN = 1'b1;
      #12;
      apply_reset(1'b1);

      // Fixed vectors: IDLE ignores counts, first writes, simultaneous newSeq and advance
      for (int i = 0; i < 8; i++) begin
         newSeq = vecs[i].ns; colorCount = vecs[i].cc; colorIn = vecs[i].ci;
         rdReq = vecs[i].rd; brickIndex = vecs[i].idx;
         step(1'b0);
         chk($sformatf("vec%0d_color", i), 32'(brickColor), 32'(vecs[i].e_color));
         chk($sformatf("vec%0d_valid", i), 32'(rdValid),    32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_ready", i), 32'(tableReady), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_fill", i),  32'(fillCount),  32'(vecs[i].e_fill));
      end
      newSeq = 1'b0; rdReq = 1'b0;
      wait_ready("vec_stall_cycles", LIMIT);
      chk("vec_stall_err",  32'(stallErr),  32'd1);
      chk("vec_stall_fill", 32'(fillCount), 32'd1);
      do_read(8'd5, 8'h11, "vec_rd5");
      do_read(8'd6, 8'h22, "vec_rd6");
      do_read(8'd7, 8'hFF, "vec_rd7_nowrite");
      do_read(8'd8, 8'h55, "vec_rd8");

      // Full fill, counts 1..255, each entry holds its index ^ 5A
      apply_reset(1'b0);
      colorCount = 8'd0; newSeq = 1'b1;
      step(1'b1);
      newSeq = 1'b0;
      for (int c = 1; c <= 255; c++) begin
         colorCount = 8'(c);
         colorIn = 8'(c - 1) ^ 8'h5A;
         rdReq = ((c % 17) == 0);
         brickIndex = 8'(c);
         step(1'b1);
         if ((c % 17) == 0) chk("fill_read_default", 32'(brickColor), 32'(DEF));
      end
      rdReq = 1'b0;
      chk("full_ready", 32'(tableReady), 32'd1);
      chk("full_fill",  32'(fillCount),  32'd255);
      do_read(8'd9,   8'h53, "full_rd9");
      do_read(8'd255, 8'hFF, "full_rd255");
      rdReq = 1'b1; brickIndex = 8'd3;
      step(1'b1);
      rdReq = 1'b0;
      chk("lat_valid_hi", 32'(rdValid),    32'd1);
      chk("lat_color",    32'(brickColor), 32'h59);
      step(1'b1);
      chk("lat_valid_lo", 32'(rdValid),    32'd0);
      chk("lat_hold",     32'(brickColor), 32'h59);

      // Stall after 10 advances; unwritten entries keep old contents
      newSeq = 1'b1;
      step(1'b1);
      newSeq = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         colorCount = 8'(c);
         colorIn = 8'(c) ^ 8'hC3;
         step(1'b1);
      end
      wait_ready("stall_cycles", LIMIT);
      chk("stall_err",  32'(stallErr),  32'd1);
      chk("stall_fill", 32'(fillCount), 32'd10);
      do_read(8'd0,  8'hC2, "stall_rd0");
      do_read(8'd20, 8'h4E, "stall_rd20_old");

      // Reset in the middle of a fill
      newSeq = 1'b1;
      step(1'b1);
      newSeq = 1'b0;
      for (int c = 11; c <= 110; c++) begin
         colorCount = 8'(c);
         colorIn = 8'(c);
         rdReq = (c == 110);
         step(1'b1);
      end
      rdReq = 1'b0;
      chk("mid_fill100", 32'(fillCount), 32'd100);
      apply_reset(1'b1);
      newSeq = 1'b1;
      step(1'b1);
      newSeq = 1'b0;
      do_read(8'd5, 8'hFF, "mid_rd_notready");
      wait_ready("mid_stall_cycles", LIMIT - 1);
      do_read(8'd9,  8'hFF, "mid_rd9_cleared");
      do_read(8'd50, 8'hFF, "mid_rd50_cleared");

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         newSeq = ($urandom_range(0, 63) == 0);
         if (newSeq) begin
            colorCount = 8'($urandom_range(0, 200));
         end else if ($urandom_range(0, 2) != 0 && colorCount != 8'd255) begin
            colorCount = colorCount + 8'd1;
         end
         colorIn = 8'($urandom);
         rdReq = ($urandom_range(0, 1) == 1);
         brickIndex = 8'($urandom);
         step(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
